// File: rtl/mult_result_stage_pkg.sv
// Shared multiplier constants: operand/product widths and datapath latency.
package mult_result_stage_pkg;

   localparam int unsigned MULT_OP_W   = 8;
   localparam int unsigned MULT_PROD_W = 2 * MULT_OP_W;
   // Cycles from operand capture in the input register to a valid product.
   localparam int unsigned MULT_LAT    = 1;

endpackage

// File: rtl/result_fifo.sv
// Result FIFO: storage, wrapping pointers, occupancy level, full/empty flags.
// A push while full is only accepted when a pop happens in the same cycle.
module result_fifo
   import mult_result_stage_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_PROD_W,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_level == LVL_W'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign w_push_ok = i_push & (~o_full | i_pop);
   assign w_pop_ok  = i_pop & ~o_empty;
   assign o_data    = r_mem[r_rd_ptr];
   assign o_level   = r_level;

   // Storage write; cleared on reset so the head reads zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointers wrap naturally modulo DEPTH (power of two).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   // Occupancy: unchanged when push and pop coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= '0;
      end else begin
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/mult_result_stage.sv
// Multiplier result stage: issues operand credit upstream, tracks accepted
// operands through the fixed-latency datapath, captures products into a FIFO
// and delivers them downstream over valid/ready.
module mult_result_stage
   import mult_result_stage_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_PROD_W,
   parameter int unsigned LAT   = MULT_LAT,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     op_valid,
   output logic                     op_ready,
   input  logic [WIDTH-1:0]         prod,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf_err
);

   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic [LAT-1:0]   r_tok;
   logic [LVL_W-1:0] r_inflight;
   logic             r_ovf_err;
   logic             w_acc;
   logic             w_cap;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [LVL_W:0]   w_credit_sum;

   assign w_acc     = op_valid & op_ready;
   assign w_cap     = r_tok[LAT-1];
   assign w_pop     = out_valid & out_ready;
   assign out_valid = ~w_empty;
   assign ovf_err   = r_ovf_err;

   // Credit from registered level and in-flight count only, so a pop in the
   // current cycle does not free a slot until the next cycle.
   assign w_credit_sum = {1'b0, level} + {1'b0, r_inflight};
   assign op_ready     = (w_credit_sum < (LVL_W + 1)'(DEPTH));

   // Token pipeline mirroring the datapath latency; the tail marks prod valid.
   if (LAT == 1) begin : g_tok_single
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) r_tok <= '0;
         else        r_tok <= w_acc;
      end
   end else begin : g_tok_multi
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) r_tok <= '0;
         else        r_tok <= {r_tok[LAT-2:0], w_acc};
      end
   end

   // Count of accepted operands whose product has not yet been captured.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_inflight <= '0;
      end else begin
         case ({w_acc, w_cap})
            2'b10:   r_inflight <= r_inflight + LVL_W'(1);
            2'b01:   r_inflight <= r_inflight - LVL_W'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Sticky overflow: a product arrived with no room; credit should prevent it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovf_err <= 1'b0;
      end else if (w_cap & w_full & ~w_pop) begin
         r_ovf_err <= 1'b1;
      end
   end

   result_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_result_fifo (
      .clk         (clk),
      .rst_n       (reset),
      .i_push      (w_cap),
      .i_push_data (prod),
      .i_pop       (w_pop),
      .o_data      (out_data),
      .o_level     (level),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

endmodule

// File: tb/tb_mult_result_stage.sv
// Scoreboard bench for mult_result_stage with LAT=1, DEPTH=4.
module tb_mult_result_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [15:0] prod;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  level;
   logic        ovf_err;

   logic [15:0] sb [$];
   int          n_vec = 0;
   int          n_err = 0;
   logic        pend_v = 1'b0;
   logic [15:0] pend_d = '0;
   logic        acc_now;
   logic        popped;
   logic [15:0] pdata;
   logic [15:0] exp_d;

   always #5 clk = ~clk;

   mult_result_stage #(
      .WIDTH (16),
      .LAT   (1),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .prod      (prod),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .ovf_err   (ovf_err)
   );

   // One cycle: drive inputs at negedge, present the product of last cycle's
   // accept (pushing its expectation), then sample handshakes for this cycle.
   task automatic step(input logic ov, input logic ordy, input logic [15:0] d);
      @(negedge clk);
      op_valid  = ov;
      out_ready = ordy;
      if (pend_v) begin
         prod = pend_d;
         sb.push_back(pend_d);
      end else begin
         prod = 16'hDEAD;
      end
      #1;
      popped  = out_valid & out_ready;
      pdata   = out_data;
      acc_now = op_valid & op_ready;
      pend_v  = acc_now;
      pend_d  = d;
   endtask

   task automatic test_reset;
      reset = 1'b0; op_valid = 1'b0; out_ready = 1'b0; prod = '0;
      repeat (2) @(negedge clk);
      n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL rst_op_ready got %b exp 1", op_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level got %0d exp 0", level); end
      n_vec++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b exp 0", ovf_err); end
      n_vec++; if (out_data !== 16'h0) begin n_err++; $display("FAIL rst_out_data got %h exp 0000", out_data); end
      reset = 1'b1;
   endtask

   task automatic test_drain;
      logic done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         step(1'b0, 1'b1, 16'h0);
         if (popped) begin
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL drain_pop got %h exp none", pdata); end
            else begin exp_d = sb.pop_front(); if (pdata !== exp_d) begin n_err++; $display("FAIL drain_data got %h exp %h", pdata, exp_d); end end
         end else if (!pend_v && !out_valid) begin
            done = 1'b1;
         end
      end
      n_vec++; if (!done || sb.size() != 0) begin n_err++; $display("FAIL drain_done got left=%0d exp 0", sb.size()); end
      n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL drain_level got %0d exp 0", level); end
   endtask

   task automatic test_single;
      for (int c = 0; c < 4; c++) begin
         step((c == 0), 1'b1, 16'h1234);
         if (c == 0) begin n_vec++; if (acc_now !== 1'b1) begin n_err++; $display("FAIL single_acc got %b exp 1", acc_now); end end
         n_vec++; if (out_valid !== (c == 2)) begin n_err++; $display("FAIL single_valid_c%0d got %b exp %b", c, out_valid, (c == 2)); end
         if (popped) begin
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL single_pop got %h exp none", pdata); end
            else begin exp_d = sb.pop_front(); if (pdata !== exp_d || pdata !== 16'h1234) begin n_err++; $display("FAIL single_data got %h exp 1234", pdata); end end
         end
      end
   endtask

   task automatic test_backpressure;
      int n_acc = 0;
      for (int c = 0; c < 8; c++) begin
         step(1'b1, 1'b0, 16'hA000 + 16'(n_acc));
         if (acc_now) n_acc++;
      end
      n_vec++; if (n_acc != 4) begin n_err++; $display("FAIL bp_accepts got %0d exp 4", n_acc); end
      n_vec++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL bp_op_ready got %b exp 0", op_ready); end
      n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL bp_level got %0d exp 4", level); end
      n_vec++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL bp_ovf got %b exp 0", ovf_err); end
   endtask

   task automatic test_credit_return;
      step(1'b0, 1'b1, 16'h0);
      n_vec++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL credit_same_cycle got %b exp 0", op_ready); end
      n_vec++;
      if (!popped || sb.size() == 0) begin n_err++; $display("FAIL credit_pop got %b exp 1", popped); end
      else begin exp_d = sb.pop_front(); if (pdata !== exp_d) begin n_err++; $display("FAIL credit_data got %h exp %h", pdata, exp_d); end end
      step(1'b0, 1'b0, 16'h0);
      n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL credit_next_cycle got %b exp 1", op_ready); end
      n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL credit_level got %0d exp 3", level); end
      test_drain();
   endtask

   task automatic test_streaming;
      int n_acc = 0;
      int n_pop = 0;
      for (int c = 0; c < 21; c++) begin
         step((c < 20), 1'b1, 16'(n_acc * 3));
         if (acc_now) n_acc++;
         if (c < 20) begin
            n_vec++; if (level > 3'd1) begin n_err++; $display("FAIL stream_level_c%0d got %0d exp <=1", c, level); end
            n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready_c%0d got %b exp 1", c, op_ready); end
         end
         if (popped) begin
            n_pop++;
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL stream_pop got %h exp none", pdata); end
            else begin exp_d = sb.pop_front(); if (pdata !== exp_d) begin n_err++; $display("FAIL stream_data got %h exp %h", pdata, exp_d); end end
         end
      end
      n_vec++; if (n_acc != 20) begin n_err++; $display("FAIL stream_accepts got %0d exp 20", n_acc); end
      n_vec++; if (n_pop != 19) begin n_err++; $display("FAIL stream_outputs got %0d exp 19", n_pop); end
      test_drain();
   endtask

   task automatic test_wrap;
      int n_acc = 0;
      for (int c = 0; c < 3; c++) begin
         step(1'b1, 1'b0, 16'hC000 + 16'(n_acc));
         if (acc_now) n_acc++;
      end
      for (int c = 0; c < 6; c++) begin
         step(1'b1, 1'b1, 16'hC000 + 16'(n_acc));
         if (acc_now) n_acc++;
         n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL wrap_level_c%0d got %0d exp 2", c, level); end
         n_vec++;
         if (!popped || sb.size() == 0) begin n_err++; $display("FAIL wrap_pop_c%0d got %b exp 1", c, popped); end
         else begin exp_d = sb.pop_front(); if (pdata !== exp_d) begin n_err++; $display("FAIL wrap_data got %h exp %h", pdata, exp_d); end end
      end
      test_drain();
   endtask

   task automatic test_reset_midstream;
      for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 16'hE000 + 16'(c));
      @(negedge clk);
      op_valid = 1'b0;
      n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL mid_pre_level got %0d exp 2", level); end
      reset = 1'b0;
      #1;
      pend_v = 1'b0;
      sb.delete();
      n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_op_ready got %b exp 1", op_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
      n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL mid_rst_level got %0d exp 0", level); end
      n_vec++; if (out_data !== 16'h0) begin n_err++; $display("FAIL mid_rst_data got %h exp 0000", out_data); end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step(1'b0, 1'b1, 16'h0);
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale_valid_c%0d got %b exp 0", c, out_valid); end
         n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL mid_post_ready_c%0d got %b exp 1", c, op_ready); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_credit_return();
      test_streaming();
      test_wrap();
      test_reset_midstream();
      n_vec++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL final_ovf got %b exp 0", ovf_err); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "bench time limit expired");
   end

endmodule
